// File: rtl/rf_trace_capture.sv
// Register-file change tracer: snapshots rf0..rf7 each edge and queues {reg, data, cycle} change events.
// Optional RF_TRACE_TIMESTAMP_EN adds the cycle counter and per-event timestamps; otherwise ev_cycle reads 0.
module rf_trace_capture #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] rf0,
  input  logic [31:0] rf1,
  input  logic [31:0] rf2,
  input  logic [31:0] rf3,
  input  logic [31:0] rf4,
  input  logic [31:0] rf5,
  input  logic [31:0] rf6,
  input  logic [31:0] rf7,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [2:0]  ev_reg,
  output logic [31:0] ev_data,
  output logic [31:0] ev_cycle,
  output logic [15:0] coalesce_cnt
);

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned NW   = 4;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
`ifdef RF_TRACE_TIMESTAMP_EN
    logic [DW-1:0] cycle;
`endif
  } ev_t;

  typedef enum logic {ST_BASELINE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf      [NREG];
  logic [DW-1:0]   prev_q  [NREG];
  logic [DW-1:0]   prev_d  [NREG];
  logic [DW-1:0]   pdata_q [NREG];
  logic [DW-1:0]   pdata_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   coal_d;
  logic [CW:0]     coal_sum;
  logic [NW-1:0]   ncoal;
  logic [RW-1:0]   sel;
  logic            push, pop;
  ev_t             push_ev, head;
  ev_t             mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            empty_q, full_q;
`ifdef RF_TRACE_TIMESTAMP_EN
  logic [DW-1:0]   cnt_q;
  logic [DW-1:0]   pcyc_q [NREG];
  logic [DW-1:0]   pcyc_d [NREG];
`endif

  assign rf[0] = rf0;
  assign rf[1] = rf1;
  assign rf[2] = rf2;
  assign rf[3] = rf3;
  assign rf[4] = rf4;
  assign rf[5] = rf5;
  assign rf[6] = rf6;
  assign rf[7] = rf7;

  assign pop = !empty_q && ev_ready;

  // Change detection, pending/coalesce bookkeeping and lowest-index push selection
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ncoal   = '0;
    sel     = '0;
    for (int i = 0; i < NREG; i++) begin
      prev_d[i]  = prev_q[i];
      pdata_d[i] = pdata_q[i];
`ifdef RF_TRACE_TIMESTAMP_EN
      pcyc_d[i]  = pcyc_q[i];
`endif
    end
    for (int i = NREG - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = RW'(i);
    end
    push = (state_q == ST_RUN) && (|pend_q) && !full_q;

    case (state_q)
      ST_BASELINE: begin
        for (int i = 0; i < NREG; i++) prev_d[i] = rf[i];
        state_d = ST_RUN;
      end
      ST_RUN: begin
        for (int i = 0; i < NREG; i++) begin
          if (rf[i] != prev_q[i]) begin
            prev_d[i]  = rf[i];
            pend_d[i]  = 1'b1;
            pdata_d[i] = rf[i];
`ifdef RF_TRACE_TIMESTAMP_EN
            pcyc_d[i]  = cnt_q;
`endif
            if (pend_q[i] && !(push && sel == RW'(i))) ncoal = ncoal + NW'(1);
          end else if (push && sel == RW'(i)) begin
            pend_d[i] = 1'b0;
          end
        end
      end
      default: state_d = ST_BASELINE;
    endcase

    coal_sum = {1'b0, coalesce_cnt} + (CW + 1)'(ncoal);
    coal_d   = coal_sum[CW] ? {CW{1'b1}} : coal_sum[CW-1:0];
  end

  always_comb begin
    push_ev.idx   = sel;
    push_ev.data  = pdata_q[sel];
`ifdef RF_TRACE_TIMESTAMP_EN
    push_ev.cycle = pcyc_q[sel];
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_BASELINE;
      pend_q       <= '0;
      coalesce_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        prev_q[i]  <= '0;
        pdata_q[i] <= '0;
`ifdef RF_TRACE_TIMESTAMP_EN
        pcyc_q[i]  <= '0;
`endif
      end
`ifdef RF_TRACE_TIMESTAMP_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      coalesce_cnt <= coal_d;
      prev_q       <= prev_d;
      pdata_q      <= pdata_d;
`ifdef RF_TRACE_TIMESTAMP_EN
      pcyc_q       <= pcyc_d;
      cnt_q        <= cnt_q + DW'(1);
`endif
    end
  end

  // Event FIFO: full is judged before this edge's pop, so a full FIFO never pushes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= (wr_ptr + AW'(1)) == rd_ptr;
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= (rd_ptr + AW'(1)) == wr_ptr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ev;
  end

  assign head     = mem[rd_ptr];
  assign ev_valid = !empty_q;
  assign ev_reg   = ev_valid ? head.idx  : '0;
  assign ev_data  = ev_valid ? head.data : '0;
`ifdef RF_TRACE_TIMESTAMP_EN
  assign ev_cycle = ev_valid ? head.cycle : '0;
`else
  assign ev_cycle = '0;
`endif

endmodule

// File: tb/tb_rf_trace_capture.sv
// Directed bench for rf_trace_capture: idle, single event, same-edge ordering, full/coalesce, stall, async reset.
module tb_rf_trace_capture;

`ifdef RF_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] rf [8];
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_reg;
  logic [31:0] ev_data;
  logic [31:0] ev_cycle;
  logic [15:0] coalesce_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_trace_capture #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rf0          (rf[0]),
    .rf1          (rf[1]),
    .rf2          (rf[2]),
    .rf3          (rf[3]),
    .rf4          (rf[4]),
    .rf5          (rf[5]),
    .rf6          (rf[6]),
    .rf7          (rf[7]),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_reg       (ev_reg),
    .ev_data      (ev_data),
    .ev_cycle     (ev_cycle),
    .coalesce_cnt (coalesce_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int r, input logic [31:0] d, input int c);
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    check({tag, "_reg"},   32'(ev_reg),   32'(r));
    check({tag, "_data"},  ev_data,       d);
    check({tag, "_cycle"}, ev_cycle,      TS_EN ? 32'(c) : 32'd0);
  endtask

  // Called at a negedge; the next posedge after return is edge 0 (baseline)
  task automatic do_reset();
    n_rst = 1'b0;
    step(1);
    n_rst = 1'b1;
  endtask

  typedef struct {
    int          r;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t drain [9];
  bit   seen;

  initial begin
    n_rst    = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    step(1);
    check("rst_valid",    32'(ev_valid),     32'd0);
    check("rst_reg",      32'(ev_reg),       32'd0);
    check("rst_data",     ev_data,           32'd0);
    check("rst_cycle",    ev_cycle,          32'd0);
    check("rst_coalesce", 32'(coalesce_cnt), 32'd0);

    // Constant register file: no events for 20 cycles
    n_rst = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (ev_valid) seen = 1'b1;
    end
    check("idle_valid",    32'(seen),         32'd0);
    check("idle_coalesce", 32'(coalesce_cnt), 32'd0);

    // Single change sampled at edge 5, visible after edge 6
    do_reset();
    step(5);
    rf[3] = 32'h0000_002A;
    step(1);
    check("single_early", 32'(ev_valid), 32'd0);
    step(1);
    check_head("single", 3, 32'h0000_002A, 5);
    step(1);
    check("single_popped", 32'(ev_valid), 32'd0);

    // Three registers change on edge 8; pushed lowest index first
    rf[1] = 32'h1111_1111;
    rf[4] = 32'h0000_0044;
    rf[6] = 32'h0000_0066;
    step(2);
    check_head("multi_r1", 1, 32'h1111_1111, 8);
    step(1);
    check_head("multi_r4", 4, 32'h0000_0044, 8);
    step(1);
    check_head("multi_r6", 6, 32'h0000_0066, 8);
    step(1);
    check("multi_empty", 32'(ev_valid), 32'd0);

    // Fill FIFO with consumer stalled, coalesce rf7, then stall-and-coalesce rf2 while full
    ev_ready = 1'b0;
    do_reset();
    step(1);
    for (int i = 0; i < 8; i++) rf[i] = 32'h100 + 32'(i);
    step(4);
    rf[7] = 32'hDEAD_BEEF;
    step(1);
    check("coal_first", 32'(coalesce_cnt), 32'd1);
    step(4);
    rf[2] = 32'h0000_2222;
    step(1);
    rf[2] = 32'h0000_3333;
    step(1);
    check("coal_full", 32'(coalesce_cnt), 32'd2);
    check_head("stall_a", 0, 32'h100, 1);
    step(3);
    check_head("stall_b", 0, 32'h100, 1);

    for (int i = 0; i < 7; i++) drain[i] = '{i, 32'h100 + 32'(i), 1};
    drain[7] = '{7, 32'hDEAD_BEEF, 5};
    drain[8] = '{2, 32'h0000_3333, 11};
    ev_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      check_head($sformatf("drain%0d", j), drain[j].r, drain[j].d, drain[j].c);
      step(1);
    end
    check("drain_empty", 32'(ev_valid), 32'd0);

    // Queue three events, then an asynchronous reset mid-cycle
    ev_ready = 1'b0;
    rf[0] = 32'h0000_00A0;
    rf[1] = 32'h0000_00A1;
    rf[2] = 32'h0000_00A2;
    step(4);
    check_head("queued", 0, 32'h0000_00A0, 24);
    #2 n_rst = 1'b0;
    #1;
    check("async_valid",    32'(ev_valid),     32'd0);
    check("async_reg",      32'(ev_reg),       32'd0);
    check("async_data",     ev_data,           32'd0);
    check("async_cycle",    ev_cycle,          32'd0);
    check("async_coalesce", 32'(coalesce_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (ev_valid) seen = 1'b1;
    end
    check("rebaseline_quiet", 32'(seen), 32'd0);
    rf[5] = 32'h0000_0055;
    step(2);
    check_head("post_reset", 5, 32'h0000_0055, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
